trim_gain: RTL and testbench

//  Zipper-free digital trim stage directly downstream of the polarity-invert stage. Takes its

---
 rtl/channel_strip_pkg.sv | 33 +++
 rtl/trim_gain_round_sat.sv | 53 +++++
 rtl/trim_gain.sv | 161 ++++++++++++++++
 tb/tb_trim_gain.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/channel_strip_pkg.sv
// -----------------------------------------------------------------------------
// channel_strip_pkg
//  Shared types and constants for the channel-strip processing stages
//  (polarity, trim/gain, EQ, dynamics).
//  Contents:
//   sample_t      16-bit signed audio sample
//   gain_t        16-bit unsigned Q4.12 gain word
//   SAMPLE_W      audio sample width
//   GAIN_W_DEF    gain word width
//   GAIN_FRAC     gain fractional bits
//   GAIN_UNITY    Q4.12 unity gain
//   GAIN_STEP_DEF default gain slew per accepted sample
//   gain_state_e  gain ramp FSM states
// -----------------------------------------------------------------------------
package channel_strip_pkg;

    localparam int unsigned SAMPLE_W      = 16;
    localparam int unsigned GAIN_W_DEF    = 16;
    localparam int unsigned GAIN_FRAC     = 12;
    localparam int unsigned GAIN_STEP_DEF = 16;

    localparam logic [GAIN_W_DEF-1:0] GAIN_UNITY = 16'd4096;

    typedef logic signed [SAMPLE_W-1:0] sample_t;
    typedef logic [GAIN_W_DEF-1:0]      gain_t;

    typedef enum logic [1:0] {
        G_IDLE = 2'd0,
        G_UP   = 2'd1,
        G_DOWN = 2'd2
    } gain_state_e;

endpackage : channel_strip_pkg

// File: rtl/trim_gain_round_sat.sv
// -----------------------------------------------------------------------------
// round_sat
//  Combinational fixed-point rescale: rounds a wide signed product by FRAC
//  bits (half toward +inf) and saturates to an OUT_W-bit signed sample.
//  Ports:
//   i_prod      in   PROD_W  signed product
//   o_sample_c  out  OUT_W   rounded, saturated sample
//   o_clip_c    out  1       high when saturation was applied
// -----------------------------------------------------------------------------
module round_sat #(
    parameter int unsigned PROD_W = 33,
    parameter int unsigned FRAC   = 12,
    parameter int unsigned OUT_W  = 16
) (
    input  logic signed [PROD_W-1:0] i_prod,
    output logic signed [OUT_W-1:0]  o_sample_c,
    output logic                     o_clip_c
);

    // One guard bit so adding the rounding constant can never overflow.
    localparam int unsigned SUM_W = PROD_W + 1;

    localparam logic signed [SUM_W-1:0] RND_C = SUM_W'(1) << (FRAC - 1);
    localparam logic signed [SUM_W-1:0] MAX_C =
        {{(SUM_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] MIN_C =
        {{(SUM_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [SUM_W-1:0] w_sum;
    logic signed [SUM_W-1:0] w_shr;
    logic                    w_hi;
    logic                    w_lo;

    // Add half an output LSB, then floor-shift: rounds half toward +inf.
    assign w_sum = {i_prod[PROD_W-1], i_prod} + RND_C;
    assign w_shr = w_sum >>> FRAC;

    assign w_hi = (w_shr > MAX_C);
    assign w_lo = (w_shr < MIN_C);

    always_comb begin
        o_sample_c = w_shr[OUT_W-1:0];
        o_clip_c   = 1'b0;
        if (w_hi) begin
            o_sample_c = MAX_C[OUT_W-1:0];
            o_clip_c   = 1'b1;
        end else if (w_lo) begin
            o_sample_c = MIN_C[OUT_W-1:0];
            o_clip_c   = 1'b1;
        end
    end

endmodule : round_sat

// File: rtl/trim_gain.sv
// -----------------------------------------------------------------------------
// trim_gain
//  Zipper-free digital trim: multiplies each accepted sample by a slewed gain,
//  rounds and saturates to DATA_W signed. Gain moves toward the effective
//  target (0 while muted) by STEP per accepted sample and lands exactly on it.
//  Ports:
//   clk_48      in   1       clock, rising edge
//   reset       in   1       synchronous active-high reset
//   sampleEn    in   1       accepts one sample per high cycle
//   trimIn      in   DATA_W  signed input sample
//   gainTarget  in   GAIN_W  requested gain, unsigned Q4.12
//   mute        in   1       forces effective target to 0 (ramped)
//   trimOut     out  DATA_W  rounded, saturated output sample
//   outValid    out  1       one-cycle strobe per accepted sample
//   ramping     out  1       high while gain is not settled on target
//   clip        out  1       high with outValid when the output saturated
// -----------------------------------------------------------------------------
module trim_gain
    import channel_strip_pkg::*;
#(
    parameter int unsigned DATA_W = SAMPLE_W,
    parameter int unsigned GAIN_W = GAIN_W_DEF,
    parameter int unsigned FRAC   = GAIN_FRAC,
    parameter int unsigned STEP   = GAIN_STEP_DEF
) (
    input  logic                     clk_48,
    input  logic                     reset,
    input  logic                     sampleEn,
    input  logic signed [DATA_W-1:0] trimIn,
    input  logic        [GAIN_W-1:0] gainTarget,
    input  logic                     mute,
    output logic signed [DATA_W-1:0] trimOut,
    output logic                     outValid,
    output logic                     ramping,
    output logic                     clip
);

    localparam int unsigned PROD_W = DATA_W + GAIN_W + 1;
    localparam int unsigned CMP_W  = GAIN_W + 1;

    localparam logic [CMP_W-1:0]  STEP_X = CMP_W'(STEP);
    localparam logic [GAIN_W-1:0] STEP_G = GAIN_W'(STEP);

    // Gain ramp state
    gain_state_e              r_state;
    logic        [GAIN_W-1:0] r_cur_gain;
    logic                     r_ramping;

    // Pipeline registers
    logic signed [PROD_W-1:0] r_prod;
    logic                     r_v1;
    logic signed [DATA_W-1:0] r_trim_out;
    logic                     r_out_valid;
    logic                     r_clip;

    logic        [GAIN_W-1:0] w_eff;
    logic        [CMP_W-1:0]  w_eff_x;
    logic        [CMP_W-1:0]  w_cur_x;
    logic        [CMP_W-1:0]  w_gap_up;
    logic        [CMP_W-1:0]  w_gap_dn;
    logic                     w_go_up;
    logic                     w_go_dn;
    logic signed [GAIN_W:0]   w_gain_s;
    logic signed [PROD_W-1:0] w_prod;
    logic signed [DATA_W-1:0] w_rs_sample;
    logic                     w_rs_clip;

    assign w_eff = mute ? '0 : gainTarget;

    // Compare one bit wider than the gain so the step test never wraps near 0 or full scale.
    assign w_eff_x  = {1'b0, w_eff};
    assign w_cur_x  = {1'b0, r_cur_gain};
    assign w_go_up  = (w_eff_x > w_cur_x);
    assign w_go_dn  = (w_eff_x < w_cur_x);
    assign w_gap_up = w_eff_x - w_cur_x;
    assign w_gap_dn = w_cur_x - w_eff_x;

    // Gain is unsigned; a zero MSB makes it a non-negative signed multiplicand.
    assign w_gain_s = {1'b0, r_cur_gain};
    assign w_prod   = trimIn * w_gain_s;

    round_sat #(
        .PROD_W (PROD_W),
        .FRAC   (FRAC),
        .OUT_W  (DATA_W)
    ) u_round_sat (
        .i_prod     (r_prod),
        .o_sample_c (w_rs_sample),
        .o_clip_c   (w_rs_clip)
    );

    // Gain ramp FSM: direction is re-derived from the effective target on every accepted sample.
    always_ff @(posedge clk_48) begin
        if (reset) begin
            r_state    <= G_IDLE;
            r_cur_gain <= '0;
            r_ramping  <= 1'b0;
        end else if (sampleEn) begin
            if (w_go_up) begin
                if (w_gap_up <= STEP_X) begin
                    r_cur_gain <= w_eff;
                    r_state    <= G_IDLE;
                    r_ramping  <= 1'b0;
                end else begin
                    r_cur_gain <= r_cur_gain + STEP_G;
                    r_state    <= G_UP;
                    r_ramping  <= 1'b1;
                end
            end else if (w_go_dn) begin
                if (w_gap_dn <= STEP_X) begin
                    r_cur_gain <= w_eff;
                    r_state    <= G_IDLE;
                    r_ramping  <= 1'b0;
                end else begin
                    r_cur_gain <= r_cur_gain - STEP_G;
                    r_state    <= G_DOWN;
                    r_ramping  <= 1'b1;
                end
            end else begin
                r_state   <= G_IDLE;
                r_ramping <= 1'b0;
            end
        end
    end

    // Stage 1: multiply by the pre-update gain.
    always_ff @(posedge clk_48) begin
        if (reset) begin
            r_prod <= '0;
            r_v1   <= 1'b0;
        end else begin
            r_v1 <= sampleEn;
            if (sampleEn) begin
                r_prod <= w_prod;
            end
        end
    end

    // Stage 2: round, saturate and register the result; trimOut holds between samples.
    always_ff @(posedge clk_48) begin
        if (reset) begin
            r_trim_out  <= '0;
            r_out_valid <= 1'b0;
            r_clip      <= 1'b0;
        end else begin
            r_out_valid <= r_v1;
            if (r_v1) begin
                r_trim_out <= w_rs_sample;
                r_clip     <= w_rs_clip;
            end else begin
                r_clip <= 1'b0;
            end
        end
    end

    assign trimOut  = r_trim_out;
    assign outValid = r_out_valid;
    assign clip     = r_clip;
    assign ramping  = r_ramping;

endmodule : trim_gain

// File: tb/tb_trim_gain.sv
// -----------------------------------------------------------------------------
// tb_trim_gain
//  Randomized scoreboard bench for trim_gain. The driver updates a behavioural
//  gain/rounding model and queues expected outputs; the monitor pops and
//  compares whenever outValid is seen.
// -----------------------------------------------------------------------------
module tb_trim_gain;

    logic               clk_48 = 1'b0;
    logic               reset = 1'b1;
    logic               sampleEn = 1'b0;
    logic signed [15:0] trimIn = '0;
    logic        [15:0] gainTarget = '0;
    logic               mute = 1'b0;
    logic signed [15:0] trimOut;
    logic               outValid;
    logic               ramping;
    logic               clip;

    trim_gain dut (
        .clk_48     (clk_48),
        .reset      (reset),
        .sampleEn   (sampleEn),
        .trimIn     (trimIn),
        .gainTarget (gainTarget),
        .mute       (mute),
        .trimOut    (trimOut),
        .outValid   (outValid),
        .ramping    (ramping),
        .clip       (clip)
    );

    always #5 clk_48 = ~clk_48;

    typedef struct {
        int sample;
        bit clipped;
        int due;
    } exp_t;

    exp_t q[$];

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;

    // Model state: gain as a plain integer, ramp flag, reset flag.
    int m_gain = 0;
    bit m_ramp = 1'b0;
    bit m_rst  = 1'b1;

    always @(posedge clk_48) edge_cnt <= edge_cnt + 1;

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_cnt);
        end
    endfunction

    // Reference: exact integer rescale then clamp, followed by a bounded slew toward the target.
    function automatic void model_accept(int din, int tgt, bit mu);
        longint p;
        longint r;
        int     eff;
        exp_t   e;
        eff = mu ? 0 : tgt;
        p = longint'(din) * longint'(m_gain);
        r = (p + 2048) >>> 12;
        e.clipped = (r > 32767) || (r < -32768);
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
        e.sample = int'(r);
        e.due    = edge_cnt + 2;
        q.push_back(e);
        if (eff > m_gain)      m_gain = (m_gain + 16 < eff) ? m_gain + 16 : eff;
        else if (eff < m_gain) m_gain = (m_gain - 16 > eff) ? m_gain - 16 : eff;
        m_ramp = (m_gain != eff);
    endfunction

    task automatic step(bit en, int tgt, bit mu, int din);
        @(negedge clk_48);
        reset      = 1'b0;
        m_rst      = 1'b0;
        sampleEn   = en;
        gainTarget = 16'(tgt);
        mute       = mu;
        trimIn     = 16'(din);
        if (en) model_accept(din, tgt, mu);
    endtask

    task automatic do_reset(int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_48);
            reset    = 1'b1;
            sampleEn = 1'b0;
            m_rst    = 1'b1;
            m_gain   = 0;
            m_ramp   = 1'b0;
            q.delete();
        end
    endtask

    function automatic int rnd_sample();
        return int'($urandom_range(65535)) - 32768;
    endfunction

    task automatic run_rand(int n, int tgt, bit mu);
        for (int i = 0; i < n; i++) step(1'b1, tgt, mu, rnd_sample());
    endtask

    // Monitor: checks every cycle, pops the scoreboard on each valid output.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_48);
            #1;
            if (m_rst) begin
                chk("rst_trimOut", int'(trimOut), 0);
                chk("rst_outValid", int'(outValid), 0);
                chk("rst_ramping", int'(ramping), 0);
            end else begin
                chk("ramping", int'(ramping), int'(m_ramp));
            end
            if (outValid) begin
                if (q.size() == 0) begin
                    chk("unexpected_valid", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("trimOut", int'(trimOut), e.sample);
                    chk("clip", int'(clip), int'(e.clipped));
                    chk("latency_edge", edge_cnt, e.due);
                end
            end else begin
                chk("clip_idle", int'(clip), 0);
            end
        end
    end

    initial begin
        do_reset(3);

        // Ramp 0 -> unity, then unity pass-through including full-scale values.
        run_rand(256, 4096, 1'b0);
        step(1'b1, 4096, 1'b0, 10000);
        step(1'b1, 4096, 1'b0, 32767);
        step(1'b1, 4096, 1'b0, -32768);
        step(1'b1, 4096, 1'b0, 0);

        // Half gain: rounding half toward +inf.
        run_rand(128, 2048, 1'b0);
        step(1'b1, 2048, 1'b0, 3);
        step(1'b1, 2048, 1'b0, -3);
        step(1'b1, 2048, 1'b0, 1);
        step(1'b1, 2048, 1'b0, -1);

        // Double gain: saturation both ways.
        run_rand(384, 8192, 1'b0);
        step(1'b1, 8192, 1'b0, 20000);
        step(1'b1, 8192, 1'b0, -20000);
        step(1'b1, 8192, 1'b0, 1000);

        // Mute ramp down and unmute ramp up, observed through a gain-probe input.
        run_rand(256, 4096, 1'b0);
        for (int i = 0; i < 258; i++) step(1'b1, 4096, 1'b1, 4096);
        for (int i = 0; i < 258; i++) step(1'b1, 4096, 1'b0, 4096);

        // Reversal mid-ramp: head for 8192, turn around at 6000 toward 4000.
        for (int i = 0; i < 400 && m_gain != 6000; i++) step(1'b1, 8192, 1'b0, 4096);
        chk("reach_6000", m_gain, 6000);
        for (int i = 0; i < 140; i++) step(1'b1, 4000, 1'b0, 4096);

        // Gaps in sampleEn: gain and trimOut hold.
        for (int i = 0; i < 300; i++) begin
            int tgt;
            tgt = ($urandom_range(7) == 0) ? int'($urandom_range(12000)) : int'(gainTarget);
            step(($urandom_range(3) != 0), tgt, ($urandom_range(15) == 0), rnd_sample());
        end

        // Full-scale target and back to zero: no wrap at either end.
        run_rand(4200, 16'hFFFF, 1'b0);
        run_rand(40, 16'hFFF5, 1'b0);
        run_rand(4200, 0, 1'b0);

        // Reset in the middle of a ramp with samples in flight.
        run_rand(20, 8192, 1'b0);
        do_reset(1);
        step(1'b1, 4096, 1'b0, 4096);
        step(1'b1, 4096, 1'b0, 4096);
        run_rand(40, 4096, 1'b0);

        // Drain the pipeline.
        for (int i = 0; i < 4; i++) step(1'b0, int'(gainTarget), 1'b0, 0);
        chk("scoreboard_empty", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_trim_gain
